// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response and ALU operand bundle for alu_arbiter
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*2-1:0]      req_op;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]         resp_result;
  logic                      resp_err;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [1:0]                alu_op;
  logic [DATA_W-1:0]         alu_result;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready, alu_result,
    output req_ready, resp_valid, resp_result, resp_err, alu_a, alu_b, alu_op, busy, grant_id
  );

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_result, resp_err, alu_a, alu_b, alu_op, busy, grant_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter/sequencer sharing one ALU; optional ALU_DIV_GUARD_EN
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  io_bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr, r_grant, w_sel_idx, w_probe;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REQ-1:0]  r_resp_valid, w_req_ready;
  logic [DATA_W-1:0]   r_alu_a, r_alu_b, r_resp_result, w_sel_a, w_sel_b;
  logic [1:0]          r_alu_op, w_sel_op;
  logic                w_sel_found, w_accept, w_exec_done, w_resp_done, w_div0;

  // Descending scan so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_probe     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_probe = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (io_bus.req_valid[w_probe]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_probe;
      end
    end
  end

  assign w_sel_a     = io_bus.req_a[int'(w_sel_idx)*DATA_W +: DATA_W];
  assign w_sel_b     = io_bus.req_b[int'(w_sel_idx)*DATA_W +: DATA_W];
  assign w_sel_op    = io_bus.req_op[int'(w_sel_idx)*2 +: 2];
  assign w_accept    = (r_state == IDLE) && w_sel_found;
  assign w_exec_done = (r_state == EXEC) && (r_cnt == CNT_W'(ALU_LAT - 1));
  assign w_resp_done = (r_state == RESP) && io_bus.resp_ready[r_grant];
  // Gated by rst_n so req_ready drops with reset even though it is combinational.
  assign w_req_ready = (rst_n && w_accept) ? (NUM_REQ'(1) << w_sel_idx) : '0;

`ifdef ALU_DIV_GUARD_EN
  logic r_resp_err;
  assign w_div0 = (w_sel_op == 2'd3) && (w_sel_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_err <= 1'b0;
    end else if (w_accept && w_div0) begin
      r_resp_err <= 1'b1;
    end else if (w_exec_done) begin
      r_resp_err <= 1'b0;
    end
  end

  assign io_bus.resp_err = r_resp_err;
`else
  assign w_div0          = 1'b0;
  assign io_bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_div0 ? RESP : EXEC;
      EXEC:    if (w_exec_done) w_state_nxt = RESP;
      RESP:    if (w_resp_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
      r_resp_valid  <= '0;
      r_resp_result <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= w_sel_a;
        r_alu_b  <= w_sel_b;
        r_alu_op <= w_sel_op;
        r_grant  <= w_sel_idx;
        r_rr_ptr <= (w_sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_sel_idx + 1'b1;
        r_cnt    <= '0;
        if (w_div0) begin
          r_resp_result <= '1;
          r_resp_valid  <= NUM_REQ'(1) << w_sel_idx;
        end
      end
      if (r_state == EXEC) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_exec_done) begin
        r_resp_result <= io_bus.alu_result;
        r_resp_valid  <= NUM_REQ'(1) << r_grant;
      end
      if (w_resp_done) begin
        r_resp_valid <= '0;
      end
    end
  end

  assign io_bus.req_ready   = w_req_ready;
  assign io_bus.resp_valid  = r_resp_valid;
  assign io_bus.resp_result = r_resp_result;
  assign io_bus.alu_a       = r_alu_a;
  assign io_bus.alu_b       = r_alu_b;
  assign io_bus.alu_op      = r_alu_op;
  assign io_bus.busy        = (r_state != IDLE);
  assign io_bus.grant_id    = r_grant;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter (ALU_LAT 1 and 3 instances)
module tb_alu_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(2), .DATA_W(DW)) if0();
  alu_arbiter_if #(.NUM_REQ(2), .DATA_W(DW)) if3();

  alu_arbiter #(.NUM_REQ(2), .DATA_W(DW), .ALU_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_bus(if0.slave));
  alu_arbiter #(.NUM_REQ(2), .DATA_W(DW), .ALU_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .io_bus(if3.slave));

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
    endcase
  endfunction

  assign if0.alu_result = alu_f(if0.alu_a, if0.alu_b, if0.alu_op);
  assign if3.alu_result = alu_f(if3.alu_a, if3.alu_b, if3.alu_op);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, " req_ready"}, 64'(if0.req_ready), 0);
    chk({tag, " resp_valid"}, 64'(if0.resp_valid), 0);
    chk({tag, " resp_result"}, 64'(if0.resp_result), 0);
    chk({tag, " resp_err"}, 64'(if0.resp_err), 0);
    chk({tag, " alu_a"}, 64'(if0.alu_a), 0);
    chk({tag, " alu_b"}, 64'(if0.alu_b), 0);
    chk({tag, " alu_op"}, 64'(if0.alu_op), 0);
    chk({tag, " busy"}, 64'(if0.busy), 0);
    chk({tag, " grant_id"}, 64'(if0.grant_id), 0);
  endtask

  // One isolated op on the ALU_LAT=1 instance; exp_lat counts falling edges after accept.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] exp_res, input int exp_lat, input logic exp_err, input string tag);
    int n;
    @(negedge clk);
    if0.req_valid = 2'(1 << id);
    if0.req_a[id*DW +: DW] = a;
    if0.req_b[id*DW +: DW] = b;
    if0.req_op[id*2 +: 2]  = op;
    if0.resp_ready = 2'b11;
    #1;
    chk({tag, " req_ready"}, 64'(if0.req_ready), 64'(1 << id));
    @(posedge clk);
    #1;
    if0.req_valid = 2'b00;
    chk({tag, " busy"}, 64'(if0.busy), 1);
    chk({tag, " grant_id"}, 64'(if0.grant_id), 64'(id));
    chk({tag, " alu_a"}, 64'(if0.alu_a), 64'(a));
    chk({tag, " alu_op"}, 64'(if0.alu_op), 64'(op));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (if0.resp_valid == 2'b00 && n < 12);
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " resp_valid"}, 64'(if0.resp_valid), 64'(1 << id));
    chk({tag, " resp_result"}, 64'(if0.resp_result), 64'(exp_res));
    chk({tag, " resp_err"}, 64'(if0.resp_err), 64'(exp_err));
    @(negedge clk);
    chk({tag, " back idle"}, 64'({if0.busy, if0.resp_valid}), 0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a3, b3;
    logic [1:0]  op3;

    vecs[0] = '{id: 0, a: 32'd5,          b: 32'd3, op: 2'd0, exp: 32'd8};
    vecs[1] = '{id: 1, a: 32'd20,         b: 32'd7, op: 2'd1, exp: 32'd13};
    vecs[2] = '{id: 0, a: 32'd6,          b: 32'd7, op: 2'd2, exp: 32'd42};
    vecs[3] = '{id: 1, a: 32'd100,        b: 32'd7, op: 2'd3, exp: 32'd14};
    vecs[4] = '{id: 0, a: 32'hFFFF_FFFF,  b: 32'd1, op: 2'd0, exp: 32'd0};
    vecs[5] = '{id: 1, a: 32'd3,          b: 32'd5, op: 2'd1, exp: 32'hFFFF_FFFE};

    if0.req_valid = 2'b11; if0.req_a = '0; if0.req_b = '0; if0.req_op = '0; if0.resp_ready = '0;
    if3.req_valid = 2'b00; if3.req_a = '0; if3.req_b = '0; if3.req_op = '0; if3.resp_ready = '0;
    #2;
    chk_reset0("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    if0.req_valid = 2'b00;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 2, 1'b0, $sformatf("vec%0d", i));
    end

    // Reset while EXEC with both requesters valid: everything must drop at once.
    @(negedge clk);
    if0.req_valid = 2'b01;
    if0.req_a[0 +: DW] = 32'd11; if0.req_b[0 +: DW] = 32'd2; if0.req_op[1:0] = 2'd0;
    if0.resp_ready = 2'b00;
    @(posedge clk);
    #1;
    chk("rst pre busy", 64'(if0.busy), 1);
    if0.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk_reset0("rst mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    if0.req_valid = 2'b00;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst after resp_valid", 64'(if0.resp_valid), 0);
    chk("rst after busy", 64'(if0.busy), 0);

    // Contention after reset: rr_ptr must start at 0.
    if0.req_a = {32'd6, 32'd10};
    if0.req_b = {32'd7, 32'd4};
    if0.req_op = {2'd2, 2'd1};
    if0.resp_ready = 2'b11;
    if0.req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
      n = 0;
      while (if0.req_ready == 2'b00 && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk($sformatf("cont%0d req_ready", g), 64'(if0.req_ready), (g % 2 == 0) ? 64'h1 : 64'h2);
      @(posedge clk);
      #1;
      chk($sformatf("cont%0d grant_id", g), 64'(if0.grant_id), 64'(g % 2));
      n = 0;
      while (if0.resp_valid == 2'b00 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("cont%0d resp_valid", g), 64'(if0.resp_valid), (g % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("cont%0d result", g), 64'(if0.resp_result), (g % 2 == 0) ? 64'd6 : 64'd42);
    end
    if0.req_valid = 2'b00;

    // Back-pressure on requester 0 while requester 1 waits; resp_ready[1] must be ignored.
    @(negedge clk);
    if0.req_a = {32'd20, 32'd5};
    if0.req_b = {32'd7, 32'd3};
    if0.req_op = {2'd1, 2'd0};
    if0.resp_ready = 2'b00;
    if0.req_valid = 2'b01;
    @(posedge clk);
    #1;
    if0.req_valid = 2'b10;
    if0.resp_ready = 2'b10;
    n = 0;
    while (if0.resp_valid == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d resp_valid", k), 64'(if0.resp_valid), 1);
      chk($sformatf("bp%0d result", k), 64'(if0.resp_result), 8);
      chk($sformatf("bp%0d req_ready", k), 64'(if0.req_ready), 0);
      @(negedge clk);
    end
    if0.resp_ready = 2'b01;
    @(posedge clk);
    #1;
    chk("bp release req_ready", 64'(if0.req_ready), 2);
    @(posedge clk);
    #1;
    chk("bp grant_id", 64'(if0.grant_id), 1);
    chk("bp busy", 64'(if0.busy), 1);
    if0.req_valid = 2'b00;
    if0.resp_ready = 2'b11;
    n = 0;
    while (if0.resp_valid == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp req1 result", 64'(if0.resp_result), 13);
    @(negedge clk);

`ifdef ALU_DIV_GUARD_EN
    do_op(1, 32'd9, 32'd0, 2'd3, 32'hFFFF_FFFF, 1, 1'b1, "div0 guard");
    do_op(1, 32'd9, 32'd3, 2'd3, 32'd3, 2, 1'b0, "div after guard");
`else
    do_op(1, 32'd9, 32'd0, 2'd3, 32'hDEAD_BEEF, 2, 1'b0, "div0 plain");
    do_op(1, 32'd9, 32'd3, 2'd3, 32'd3, 2, 1'b0, "div plain");
`endif

    // ALU_LAT=3 instance: operands must hold steady until the response.
    @(negedge clk);
    if3.req_valid = 2'b01;
    if3.req_a[0 +: DW] = 32'd100; if3.req_b[0 +: DW] = 32'd7; if3.req_op[1:0] = 2'd3;
    if3.resp_ready = 2'b11;
    a3 = 32'd100; b3 = 32'd7; op3 = 2'd3;
    #1;
    chk("lat3 req_ready", 64'(if3.req_ready), 1);
    @(posedge clk);
    #1;
    if3.req_valid = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk($sformatf("lat3 ops n%0d", n), {if3.alu_a, if3.alu_b[29:0], if3.alu_op}, {a3, b3[29:0], op3});
    end while (if3.resp_valid == 2'b00 && n < 12);
    chk("lat3 latency", 64'(n), 4);
    chk("lat3 resp_valid", 64'(if3.resp_valid), 1);
    chk("lat3 result", 64'(if3.resp_result), 14);
    @(negedge clk);
    chk("lat3 idle", 64'(if3.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
